// File: rtl/z80_uart_fifo.sv
// z80_uart_fifo: buffered 8N1 UART on the Z80 slave bus.
// Register map: addr 0 = DATA (TX push / RX pop), addr 1 = STATUS (read) / CTRL (write).

package z80_bus_pkg;
  typedef struct packed {
    logic       wrn;
    logic       rdn;
    logic [7:0] dmaster;
  } Z80MasterBus;

  typedef struct packed {
    logic [7:0] dslave;
    logic       mwait;
  } Z80SlaveBus;
endpackage

// Byte FIFO with wrapping pointers; the extra pointer bit separates full from empty.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module z80_uart_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// State table (both serial engines share the encoding)
//   state | TX meaning                              | RX meaning
//   IDLE  | line high, waiting for FIFO data        | waiting for a low level
//   START | driving the start bit                   | confirming start bit at its middle
//   DATA  | driving 8 bits, LSB first               | sampling 8 bits, LSB first
//   STOP  | driving stop bit, may chain next byte   | checking stop bit / waiting for line high
module z80_uart_fifo
  import z80_bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int BLOCKING     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        addr,
  input  Z80MasterBus ibus,
  output Z80SlaveBus  obus,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head, status;
  logic          mwait_i, wr_acc, rd_acc, tx_push, ctrl_wr, rx_pop;
  logic          acc_done, rd_pending;
  logic          irq_rx_en, irq_tx_en, overrun, frame_err, tx_idle;
  logic [1:0]    tx_state, rx_state;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0]    tx_bits, rx_bits;
  logic [7:0]    tx_shift, rx_shift;
  logic          tx_load;
  logic          rx_s1, rx_s2, rx_wait;
  logic          rx_stop_tick, rx_push, overrun_set, frame_set;

  assign mwait_i = !((BLOCKING != 0) && ena && !addr &&
                     ((!ibus.wrn && tx_full) || (!ibus.rdn && rx_empty)));
  assign wr_acc  = ena && !ibus.wrn && mwait_i && !acc_done;
  assign rd_acc  = ena && !ibus.rdn && mwait_i && !acc_done;
  assign tx_push = wr_acc && !addr;
  assign ctrl_wr = wr_acc && addr;
  assign rx_pop  = rd_pending && ibus.rdn;

  assign tx_idle = (tx_state == S_IDLE) && tx_empty;
  assign status  = {1'b0, irq_tx_en, irq_rx_en, tx_idle, frame_err, overrun, !tx_full, !rx_empty};
  assign obus.dslave = addr ? status : (rx_empty ? 8'h00 : rx_head);
  assign obus.mwait  = mwait_i;

  z80_uart_sync_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_load), .din(ibus.dmaster),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );

  z80_uart_sync_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift),
    .dout(rx_head), .full(rx_full), .empty(rx_empty)
  );

  // One access per bus cycle; a DATA read pops only once rdn returns high
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_done   <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      if (wr_acc || rd_acc)                    acc_done <= 1'b1;
      else if ((ibus.wrn && ibus.rdn) || !ena) acc_done <= 1'b0;
      if (rd_acc && !addr && !rx_empty) rd_pending <= 1'b1;
      else if (ibus.rdn)                rd_pending <= 1'b0;
    end
  end

  // Control register, sticky flags (a new error wins over a same-cycle clear) and irq
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_rx_en <= 1'b0;
      irq_tx_en <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_rx_en <= ibus.dmaster[5];
        irq_tx_en <= ibus.dmaster[6];
      end
      if (overrun_set)                     overrun <= 1'b1;
      else if (ctrl_wr && ibus.dmaster[2]) overrun <= 1'b0;
      if (frame_set)                       frame_err <= 1'b1;
      else if (ctrl_wr && ibus.dmaster[3]) frame_err <= 1'b0;
      irq <= (irq_rx_en && !rx_empty) || (irq_tx_en && tx_empty);
    end
  end

  // A byte is fetched from IDLE, or straight out of the last stop-bit cycle for back-to-back frames
  assign tx_load = !tx_empty && ((tx_state == S_IDLE) || ((tx_state == S_STOP) && (tx_cnt == '0)));

  // TX serial engine
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else if (tx_load) begin
      tx_state <= S_START;
      tx_cnt   <= BIT_LAST;
      tx_shift <= tx_head;
      tx       <= 1'b0;
    end else if (tx_state != S_IDLE) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CNT_ONE;
      end else begin
        tx_cnt <= BIT_LAST;
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bits  <= 3'd7;
            tx       <= tx_shift[0];
          end
          S_DATA: begin
            if (tx_bits == 3'd0) begin
              tx_state <= S_STOP;
              tx       <= 1'b1;
            end else begin
              tx_bits  <= tx_bits - 3'd1;
              tx_shift <= tx_shift >> 1;
              tx       <= tx_shift[1];
            end
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_stop_tick = (rx_state == S_STOP) && !rx_wait && (rx_cnt == '0);
  assign rx_push      = rx_stop_tick && rx_s2;
  assign overrun_set  = rx_push && rx_full && !rx_pop;
  assign frame_set    = rx_stop_tick && !rx_s2;

  // RX synchroniser and serial engine
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_wait  <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2) begin
            rx_state <= S_START;
            rx_cnt   <= BIT_HALF;
          end
        end
        S_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else if (rx_s2) begin
            rx_state <= S_IDLE;
          end else begin
            rx_state <= S_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bits  <= 3'd7;
          end
        end
        S_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            if (rx_bits == 3'd0) rx_state <= S_STOP;
            else                 rx_bits  <= rx_bits - 3'd1;
          end
        end
        default: begin
          if (rx_wait) begin
            if (rx_s2) begin
              rx_wait  <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else if (rx_s2) begin
            rx_state <= S_IDLE;
          end else begin
            rx_wait <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_z80_uart_fifo.sv
module tb_z80_uart_fifo;
  import z80_bus_pkg::*;

  localparam int CPB   = 8;
  localparam int TXD   = 4;
  localparam int RXD   = 4;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        addr = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        irq;
  Z80MasterBus ibus;
  Z80SlaveBus  obus;

  always #5 clk = ~clk;

  z80_uart_fifo #(.CLKS_PER_BIT(CPB), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .BLOCKING(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .addr(addr), .ibus(ibus), .obus(obus),
    .rx(rx), .tx(tx), .irq(irq)
  );

  int         checks = 0;
  int         errors = 0;
  logic       tx_log[$];
  logic [7:0] rx_q[$];
  logic [7:0] txb[$];
  bit         irq_rx_en_m, irq_tx_en_m, overrun_m, frame_err_m;
  logic [7:0] d, b;
  int         w, w_last, w_prev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    tx_log.push_back(tx);
  endtask

  function automatic logic [7:0] exp_status(input bit idle, input bit not_full);
    return {1'b0, irq_tx_en_m, irq_rx_en_m, idle, frame_err_m, overrun_m, not_full, rx_q.size() != 0};
  endfunction

  function automatic logic exp_irq(input bit tx_empty);
    return (irq_rx_en_m && rx_q.size() != 0) || (irq_tx_en_m && tx_empty);
  endfunction

  task automatic bus_write(input logic a, input logic [7:0] v, output int waits);
    tick();
    ena = 1'b1; addr = a; ibus.wrn = 1'b0; ibus.dmaster = v;
    #1;
    waits = 0;
    while (obus.mwait !== 1'b1 && waits < BOUND) begin
      tick(); #1; waits++;
    end
    check("wr_wait_bound", 32'(obus.mwait), 32'd1);
    tick();
    ibus.wrn = 1'b1; ena = 1'b0;
  endtask

  task automatic bus_read(input logic a, input int hold, output logic [7:0] v);
    int waits;
    tick();
    ena = 1'b1; addr = a; ibus.rdn = 1'b0;
    #1;
    waits = 0;
    while (obus.mwait !== 1'b1 && waits < BOUND) begin
      tick(); #1; waits++;
    end
    check("rd_wait_bound", 32'(obus.mwait), 32'd1);
    v = obus.dslave;
    repeat (hold) tick();
    tick();
    ibus.rdn = 1'b1; ena = 1'b0;
  endtask

  task automatic ctrl_write(input logic [7:0] v);
    int waits;
    bus_write(1'b1, v, waits);
    irq_rx_en_m = v[5];
    irq_tx_en_m = v[6];
    if (v[2]) overrun_m = 1'b0;
    if (v[3]) frame_err_m = 1'b0;
  endtask

  task automatic status_check(input string tag, input bit idle, input bit not_full);
    logic [7:0] v;
    bus_read(1'b1, 0, v);
    check(tag, 32'(v), 32'(exp_status(idle, not_full)));
  endtask

  task automatic data_read_check(input string tag);
    logic [7:0] v;
    logic [7:0] e;
    bus_read(1'b0, 0, v);
    e = rx_q.pop_front();
    check(tag, 32'(v), 32'(e));
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
    if (!stop)                   frame_err_m = 1'b1;
    else if (rx_q.size() < RXD)  rx_q.push_back(v);
    else                         overrun_m = 1'b1;
  endtask

  // Expected line: per byte, start 0, 8 data bits LSB first, stop 1, each CPB clocks, no gaps
  task automatic check_tx_log(input string tag, input logic [7:0] bytes[$]);
    int k;
    int idx;
    logic [7:0] smp;
    logic bitv;
    k = -1;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (k < 0 && tx_log[i] === 1'b0) k = i;
    end
    check({tag, "_start"}, 32'(k >= 0), 32'd1);
    if (k >= 0) begin
      for (int j = 0; j < bytes.size(); j++) begin
        for (int bi = 0; bi < 10; bi++) begin
          if (bi == 0)      bitv = 1'b0;
          else if (bi == 9) bitv = 1'b1;
          else              bitv = bytes[j][bi-1];
          for (int s = 0; s < 8; s++) begin
            idx = k + (j * 10 + bi) * CPB + s;
            smp[s] = (idx < tx_log.size()) ? tx_log[idx] : 1'bx;
          end
          check($sformatf("%s_b%0d_bit%0d", tag, j, bi), 32'(smp), bitv ? 32'hFF : 32'h00);
        end
      end
      idx = k + bytes.size() * 10 * CPB;
      check({tag, "_idle_after"}, 32'((idx < tx_log.size()) ? tx_log[idx] : 1'bx), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ibus.wrn = 1'b1; ibus.rdn = 1'b1; ibus.dmaster = 8'h00;
    irq_rx_en_m = 0; irq_tx_en_m = 0; overrun_m = 0; frame_err_m = 0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick(); #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_mwait", 32'(obus.mwait), 32'd1);
    status_check("rst_status", 1'b1, 1'b1);

    // Two back-to-back TX frames
    tx_log.delete();
    txb.delete(); txb.push_back(8'hA5); txb.push_back(8'h3C);
    bus_write(1'b0, 8'hA5, w);
    bus_write(1'b0, 8'h3C, w);
    status_check("tx_busy_status", 1'b0, 1'b1);
    repeat (20 * CPB + 10) tick();
    check_tx_log("tx2", txb);
    status_check("tx_done_status", 1'b1, 1'b1);

    // Random bytes overfilling the TX FIFO: the last write must stall
    tx_log.delete();
    txb.delete();
    for (int j = 0; j < TXD + 2; j++) txb.push_back(8'($urandom_range(255)));
    w_prev = 0; w_last = 0;
    for (int j = 0; j < TXD + 2; j++) begin
      bus_write(1'b0, txb[j], w);
      if (j == TXD) w_prev = w;
      if (j == TXD + 1) w_last = w;
    end
    check("tx_fill_nowait", 32'(w_prev), 32'd0);
    check("tx_full_blocked", 32'(w_last > 0), 32'd1);
    repeat ((TXD + 2) * 10 * CPB + 10) tick();
    check_tx_log("txr", txb);

    // Random RX frames read back
    for (int j = 0; j < 2; j++) begin
      send_frame(8'($urandom_range(255)), 1'b1);
      repeat (CPB) tick();
    end
    status_check("rx2_status", 1'b1, 1'b1);
    data_read_check("rx2_data0");
    data_read_check("rx2_data1");
    status_check("rx2_empty", 1'b1, 1'b1);

    // Overrun: RX_DEPTH+1 frames, no reads
    for (int j = 0; j < RXD + 1; j++) send_frame(8'($urandom_range(255)), 1'b1);
    repeat (CPB) tick();
    status_check("ovr_status", 1'b1, 1'b1);
    for (int j = 0; j < RXD; j++) data_read_check($sformatf("ovr_data%0d", j));
    status_check("ovr_drained", 1'b1, 1'b1);
    ctrl_write(8'h04);
    status_check("ovr_cleared", 1'b1, 1'b1);

    // Framing error
    send_frame(8'($urandom_range(255)), 1'b0);
    repeat (2 * CPB) tick();
    status_check("ferr_status", 1'b1, 1'b1);
    ctrl_write(8'h08);
    status_check("ferr_cleared", 1'b1, 1'b1);

    // Short glitch on rx is not a start bit
    rx = 1'b0; tick(); tick(); rx = 1'b1;
    repeat (4 * CPB) tick();
    status_check("glitch_status", 1'b1, 1'b1);

    // Blocking DATA read on empty RX, held low through a second arrival
    tick();
    ena = 1'b1; addr = 1'b0; ibus.rdn = 1'b0;
    #1;
    check("blk_rd_wait", 32'(obus.mwait), 32'd0);
    b = 8'($urandom_range(255));
    send_frame(b, 1'b1);
    tick(); #1;
    check("blk_rd_release", 32'(obus.mwait), 32'd1);
    check("blk_rd_data", 32'(obus.dslave), 32'(b));
    send_frame(8'($urandom_range(255)), 1'b1);
    repeat (10) tick();
    #1;
    check("blk_rd_hold", 32'(obus.dslave), 32'(b));
    tick();
    ibus.rdn = 1'b1; ena = 1'b0;
    d = rx_q.pop_front();
    tick(); tick();
    status_check("blk_one_pop", 1'b1, 1'b1);
    data_read_check("blk_second");
    status_check("blk_empty", 1'b1, 1'b1);

    // RX interrupt
    ctrl_write(8'h20);
    tick(); tick(); #1;
    check("irq_rx_idle", 32'(irq), 32'(exp_irq(1'b1)));
    status_check("irq_rx_status", 1'b1, 1'b1);
    send_frame(8'($urandom_range(255)), 1'b1);
    tick(); tick(); #1;
    check("irq_rx_set", 32'(irq), 32'(exp_irq(1'b1)));
    data_read_check("irq_rx_data");
    tick(); #1;
    check("irq_rx_pop_edge", 32'(irq), 32'd1);
    tick(); #1;
    check("irq_rx_clear", 32'(irq), 32'(exp_irq(1'b1)));

    // TX-empty interrupt
    ctrl_write(8'h40);
    tick(); tick(); #1;
    check("irq_tx_set", 32'(irq), 32'(exp_irq(1'b1)));
    status_check("irq_tx_status", 1'b1, 1'b1);

    // Reset in the middle of TX and RX frames
    bus_write(1'b0, 8'($urandom_range(255)), w);
    rx = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    tick(); #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_irq", 32'(irq), 32'd0);
    rst = 1'b0; rx = 1'b1;
    rx_q.delete(); irq_rx_en_m = 0; irq_tx_en_m = 0; overrun_m = 0; frame_err_m = 0;
    repeat (12 * CPB) tick();
    #1;
    check("midrst_tx_idle", 32'(tx), 32'd1);
    status_check("midrst_status", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
